// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream in, instruction-memory write port out.
// The loader sits on the slave side; the program source drives the master side.
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [4:0]        in_rd;
   logic [4:0]        in_rn;
   logic [4:0]        in_rm;
   logic [25:0]       in_imm;
   logic              in_last;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport master (
      output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes LEGv8-subset field bundles into 32-bit words and writes them to
// instruction memory one cycle after acceptance, starting at BASE_ADDR.
module instr_encoder_loader #(
   parameter int              ADDR_W    = 64,
   parameter int              DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   localparam int             CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   instr_encoder_loader_if.slave bus,
   input  logic                  restart,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  done,
   output logic                  err,
   output logic [3:0]            err_op
);

   typedef enum logic {S_LOAD, S_DONE} state_t;

   state_t            state;
   state_t            state_next;
   logic              accept;
   logic              legal;
   logic [31:0]       enc_word;
   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  cnt;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [31:0]       wr_data_q;

   assign full = (cnt == CNT_W'(DEPTH));

   // Bundle-to-word encoder; legal also folds in the per-op immediate range rules.
   always_comb begin
      enc_word = '0;
      legal    = 1'b0;
      case (bus.in_op)
         4'd0: begin
            enc_word = {10'h244, bus.in_imm[11:0], bus.in_rn, bus.in_rd};
            legal    = (bus.in_imm[25:12] == 14'd0);
         end
         4'd1: begin
            enc_word = {11'h558, bus.in_rm, 6'd0, bus.in_rn, bus.in_rd};
            legal    = 1'b1;
         end
         4'd2: begin
            enc_word = {11'h658, bus.in_rm, 6'd0, bus.in_rn, bus.in_rd};
            legal    = 1'b1;
         end
         4'd3: begin
            enc_word = {6'h05, bus.in_imm};
            legal    = 1'b1;
         end
         4'd4: begin
            enc_word = {6'h25, bus.in_imm};
            legal    = 1'b1;
         end
         4'd5: begin
            enc_word = {8'h54, bus.in_imm[18:0], 5'h0B};
            legal    = (bus.in_imm[25:18] == {8{bus.in_imm[18]}});
         end
         4'd6: begin
            enc_word = {8'hB4, bus.in_imm[18:0], bus.in_rd};
            legal    = (bus.in_imm[25:18] == {8{bus.in_imm[18]}});
         end
         4'd7: begin
            enc_word = {11'h6B0, 5'h1F, 6'd0, bus.in_rd, 5'd0};
            legal    = 1'b1;
         end
         4'd8: begin
            enc_word = {11'h7C2, bus.in_imm[8:0], 2'd0, bus.in_rn, bus.in_rd};
            legal    = (bus.in_imm[25:8] == {18{bus.in_imm[8]}});
         end
         4'd9: begin
            enc_word = {11'h7C0, bus.in_imm[8:0], 2'd0, bus.in_rn, bus.in_rd};
            legal    = (bus.in_imm[25:8] == {18{bus.in_imm[8]}});
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_LOAD;
      else        state <= state_next;
   end

   // Restart blocks acceptance outright so a coincident bundle is left for later.
   always_comb begin
      state_next   = state;
      bus.in_ready = 1'b0;
      case (state)
         S_LOAD:  bus.in_ready = reset && !full && !restart;
         S_DONE:  bus.in_ready = 1'b0;
         default: bus.in_ready = 1'b0;
      endcase
      accept = bus.in_valid && bus.in_ready;
      if (restart)
         state_next = S_LOAD;
      else if (accept && legal && bus.in_last)
         state_next = S_DONE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= BASE_ADDR;
         cnt       <= '0;
         err       <= 1'b0;
         err_op    <= 4'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= accept && legal;
         if (accept && legal) begin
            wr_addr_q <= ptr;
            wr_data_q <= enc_word;
         end
         if (restart) begin
            ptr    <= BASE_ADDR;
            cnt    <= '0;
            err    <= 1'b0;
            err_op <= 4'd0;
         end else if (accept) begin
            if (legal) begin
               ptr <= ptr + ADDR_W'(4);
               cnt <= cnt + CNT_W'(1);
            end else begin
               err <= 1'b1;
               if (!err) err_op <= bus.in_op;
            end
         end
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign count       = cnt;
   assign done        = (state == S_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a reference encoder feeds a scoreboard of expected writes,
// and a negedge monitor pops and compares every write the loader issues.
module tb_instr_encoder_loader;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             restart = 1'b0;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             done;
   logic             err;
   logic [3:0]       err_op;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sb[$];

   logic [63:0] m_ptr = 64'd0;
   int          m_count = 0;
   logic        m_done = 1'b0;
   logic        m_err = 1'b0;
   logic [3:0]  m_err_op = 4'd0;

   instr_encoder_loader_if #(.ADDR_W(64)) bus ();

   instr_encoder_loader #(.ADDR_W(64), .DEPTH(DEPTH), .BASE_ADDR(64'd0)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .restart (restart),
      .count   (count),
      .full    (full),
      .done    (done),
      .err     (err),
      .err_op  (err_op)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Returns {legal, word}, built arithmetically from the instruction tables.
   function automatic logic [32:0] ref_encode(input logic [3:0] op, input logic [4:0] rd,
                                              input logic [4:0] rn, input logic [4:0] rm,
                                              input logic [25:0] imm);
      int          s;
      logic [31:0] w;
      logic        ok;
      s  = int'($signed(imm));
      w  = 32'd0;
      ok = 1'b0;
      case (op)
         4'd0: begin w = (32'h244 << 22) | ((32'(imm) & 32'hFFF) << 10) | (32'(rn) << 5) | 32'(rd); ok = (imm < 26'h1000); end
         4'd1: begin w = (32'h558 << 21) | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd); ok = 1'b1; end
         4'd2: begin w = (32'h658 << 21) | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd); ok = 1'b1; end
         4'd3: begin w = (32'h05 << 26) | 32'(imm); ok = 1'b1; end
         4'd4: begin w = (32'h25 << 26) | 32'(imm); ok = 1'b1; end
         4'd5: begin w = (32'h54 << 24) | ((32'(imm) & 32'h7FFFF) << 5) | 32'h0B; ok = (s >= -262144) && (s <= 262143); end
         4'd6: begin w = (32'hB4 << 24) | ((32'(imm) & 32'h7FFFF) << 5) | 32'(rd); ok = (s >= -262144) && (s <= 262143); end
         4'd7: begin w = (32'h6B0 << 21) | (32'h1F << 16) | (32'(rd) << 5); ok = 1'b1; end
         4'd8: begin w = (32'h7C2 << 21) | ((32'(imm) & 32'h1FF) << 12) | (32'(rn) << 5) | 32'(rd); ok = (s >= -256) && (s <= 255); end
         4'd9: begin w = (32'h7C0 << 21) | ((32'(imm) & 32'h1FF) << 12) | (32'(rn) << 5) | 32'(rd); ok = (s >= -256) && (s <= 255); end
         default: ok = 1'b0;
      endcase
      return {ok, w};
   endfunction

   task automatic apply_stimulus(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                 input logic [4:0] rm, input logic [25:0] imm, input logic last);
      logic        exp_ready;
      logic [32:0] r;
      exp_t        e;
      @(negedge clk);
      restart      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_rd    = rd;
      bus.in_rn    = rn;
      bus.in_rm    = rm;
      bus.in_imm   = imm;
      bus.in_last  = last;
      #1;
      exp_ready = !m_done && (m_count != DEPTH);
      check_output("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      if (exp_ready) begin
         r = ref_encode(op, rd, rn, rm, imm);
         if (r[32]) begin
            e.addr = m_ptr;
            e.data = r[31:0];
            e.cyc  = cyc + 1;
            sb.push_back(e);
            m_ptr   = m_ptr + 64'd4;
            m_count = m_count + 1;
            if (last) m_done = 1'b1;
         end else begin
            if (!m_err) m_err_op = op;
            m_err = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
         restart      = 1'b0;
      end
      #1;
   endtask

   task automatic pulse_restart(input logic with_valid);
      @(negedge clk);
      restart      = 1'b1;
      bus.in_valid = with_valid;
      bus.in_op    = 4'd0;
      bus.in_imm   = 26'd7;
      bus.in_last  = 1'b0;
      #1;
      check_output("in_ready_restart", 64'(bus.in_ready), 64'd0);
      m_ptr    = 64'd0;
      m_count  = 0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_err_op = 4'd0;
      idle(1);
   endtask

   task automatic check_status(input string tag);
      check_output({tag, "_count"},    64'(count),        64'(m_count));
      check_output({tag, "_full"},     64'(full),         64'(m_count == DEPTH));
      check_output({tag, "_done"},     64'(done),         64'(m_done));
      check_output({tag, "_err"},      64'(err),          64'(m_err));
      check_output({tag, "_err_op"},   64'(err_op),       64'(m_err_op));
      check_output({tag, "_in_ready"}, 64'(bus.in_ready), 64'(!m_done && (m_count != DEPTH)));
   endtask

   // Scoreboard monitor: every write must match the head entry in address, data and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (bus.wr_en === 1'b1) begin
         if (sb.size() == 0) begin
            check_output("unexpected_write", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check_output("wr_addr",  bus.wr_addr,       e.addr);
            check_output("wr_data",  64'(bus.wr_data),  64'(e.data));
            check_output("wr_cycle", 64'(cyc),          64'(e.cyc));
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check_output("missing_write", 64'd0, 64'd1);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_op    = 4'd0;
      bus.in_rd    = 5'd0;
      bus.in_rn    = 5'd0;
      bus.in_rm    = 5'd0;
      bus.in_imm   = 26'd0;
      bus.in_last  = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check_output("rst_wr_en",    64'(bus.wr_en),    64'd0);
      check_output("rst_wr_addr",  bus.wr_addr,       64'd0);
      check_output("rst_wr_data",  64'(bus.wr_data),  64'd0);
      check_output("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check_output("rst_count",    64'(count),        64'd0);
      check_output("rst_done",     64'(done),         64'd0);
      check_output("rst_err",      64'(err),          64'd0);
      @(negedge clk);
      reset = 1'b1;

      // ADDI from reset state
      apply_stimulus(4'd0, 5'd1, 5'd2, 5'd0, 26'd5, 1'b0);
      idle(1);
      check_status("t1");
      pulse_restart(1'b0);
      check_status("t1_restart");

      // Back-to-back stream
      apply_stimulus(4'd1, 5'd3, 5'd1, 5'd2, 26'd0, 1'b0);
      apply_stimulus(4'd3, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b0);
      apply_stimulus(4'd5, 5'd0, 5'd0, 5'd0, 26'd2, 1'b0);
      apply_stimulus(4'd8, 5'd4, 5'd5, 5'd0, 26'h3FFFFF8, 1'b0);
      idle(2);
      check_status("t2");
      pulse_restart(1'b0);

      // Range and op rejections; err_op holds the first rejected op
      apply_stimulus(4'd0, 5'd1, 5'd1, 5'd0, 26'h1000, 1'b0);
      apply_stimulus(4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
      apply_stimulus(4'd12, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1);
      apply_stimulus(4'd6, 5'd7, 5'd0, 5'd0, 26'h0040000, 1'b0);
      apply_stimulus(4'd9, 5'd2, 5'd3, 5'd0, 26'h0000100, 1'b0);
      apply_stimulus(4'd6, 5'd7, 5'd0, 5'd0, 26'h3FFFFFF, 1'b0);
      idle(2);
      check_status("t3");
      pulse_restart(1'b1);
      check_status("t3_restart");

      // Fill to capacity with in_valid held
      apply_stimulus(4'd4, 5'd0, 5'd0, 5'd0, 26'h2000001, 1'b0);
      apply_stimulus(4'd2, 5'd9, 5'd10, 5'd11, 26'd0, 1'b0);
      apply_stimulus(4'd7, 5'd30, 5'd0, 5'd0, 26'd0, 1'b0);
      apply_stimulus(4'd9, 5'd1, 5'd2, 5'd0, 26'h00000FF, 1'b0);
      apply_stimulus(4'd1, 5'd1, 5'd1, 5'd1, 26'd0, 1'b0);
      apply_stimulus(4'd1, 5'd2, 5'd2, 5'd2, 26'd0, 1'b0);
      idle(2);
      check_status("t4");
      pulse_restart(1'b0);

      // in_last ends the program
      apply_stimulus(4'd0, 5'd1, 5'd0, 5'd0, 26'd1, 1'b0);
      apply_stimulus(4'd0, 5'd2, 5'd0, 5'd0, 26'd2, 1'b0);
      apply_stimulus(4'd0, 5'd3, 5'd0, 5'd0, 26'hFFF, 1'b1);
      apply_stimulus(4'd0, 5'd4, 5'd0, 5'd0, 26'd4, 1'b0);
      check_status("t5_done");
      idle(2);
      pulse_restart(1'b0);
      check_status("t5_restart");
      apply_stimulus(4'd3, 5'd0, 5'd0, 5'd0, 26'd16, 1'b0);
      idle(2);

      // Reset right after an accept drops the pending write
      apply_stimulus(4'd0, 5'd5, 5'd6, 5'd0, 26'd9, 1'b0);
      @(posedge clk);
      #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      m_ptr    = 64'd0;
      m_count  = 0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_err_op = 4'd0;
      #1;
      check_output("t6_wr_en",    64'(bus.wr_en),    64'd0);
      check_output("t6_wr_addr",  bus.wr_addr,       64'd0);
      check_output("t6_wr_data",  64'(bus.wr_data),  64'd0);
      check_output("t6_count",    64'(count),        64'd0);
      check_output("t6_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      apply_stimulus(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
      idle(2);
      check_status("t6");

      idle(3);
      check_output("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
